// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// The wrap helper avoids a modulo operator in the arbiter.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    // Returns (base + offset) mod channels, assuming base < channels and offset <= channels.
    function automatic int next_rr_idx(input int base, input int offset, input int channels);
        int sum;
        sum = base + offset;
        if (sum >= channels) begin
            sum = sum - channels;
        end
        return sum;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after last_grant,
// wrapping around, as a one-hot vector plus its index.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last_grant,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic found;

    // Priority walks offsets 1..CHANNELS, so last_grant itself has the lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 1; off <= CHANNELS; off++) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (!found && req[k] && (k == next_rr_idx(int'(last_grant), off, CHANNELS))) begin
                    found     = 1'b1;
                    grant[k]  = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin selection,
// feeding a one-entry registered output buffer (1-cycle latency, full throughput).
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int DWIDTH   = 2,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                             clk_i,
    input  logic                             srst_i,
    input  logic [CHANNELS-1:0][DWIDTH-1:0]  data_i,
    input  logic [CHANNELS-1:0]              valid_i,
    output logic [CHANNELS-1:0]              ready_o,
    input  logic                             mode_i,
    input  logic [SEL_W-1:0]                 direction_i,
    output logic [DWIDTH-1:0]                data_o,
    output logic                             valid_o,
    output logic [SEL_W-1:0]                 channel_o,
    input  logic                             ready_i
);

    mux_mode_t                        mode;
    logic [CHANNELS-1:0]              rr_grant;
    logic [CHANNELS-1:0]              fixed_grant;
    logic [CHANNELS-1:0]              grant;
    logic [SEL_W-1:0]                 rr_idx;
    logic [SEL_W-1:0]                 sel_idx;
    logic [CHANNELS-1:0][DWIDTH-1:0]  masked_data;
    logic [DWIDTH-1:0]                sel_data;
    logic                             can_load;
    logic                             load;

    logic                             valid_reg, valid_next;
    logic [DWIDTH-1:0]                data_reg, data_next;
    logic [SEL_W-1:0]                 channel_reg, channel_next;
    logic [SEL_W-1:0]                 last_grant_reg, last_grant_next;

    assign mode = mux_mode_t'(mode_i);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arbiter (
        .req        (valid_i),
        .last_grant (last_grant_reg),
        .grant      (rr_grant),
        .grant_idx  (rr_idx)
    );

    assign grant    = (mode == MODE_RR) ? rr_grant : fixed_grant;
    assign sel_idx  = (mode == MODE_RR) ? rr_idx : direction_i;
    assign can_load = ~valid_reg | ready_i;
    assign load     = |ready_o;

    // An out-of-range direction_i matches no channel, so it simply produces no grant.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign fixed_grant[gi] = valid_i[gi] & (direction_i == SEL_W'(gi));
            assign ready_o[gi]     = grant[gi] & can_load & ~srst_i;
            assign masked_data[gi] = grant[gi] ? data_i[gi] : '0;
        end
    endgenerate

    // Grant is one-hot or zero, so an OR-reduction is a clean data mux.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_data = sel_data | masked_data[k];
        end
    end

    always_comb begin
        valid_next      = valid_reg;
        data_next       = data_reg;
        channel_next    = channel_reg;
        last_grant_next = last_grant_reg;
        if (load) begin
            valid_next      = 1'b1;
            data_next       = sel_data;
            channel_next    = sel_idx;
            last_grant_next = sel_idx;
        end else if (ready_i) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            channel_reg    <= '0;
            last_grant_reg <= SEL_W'(CHANNELS - 1);
        end else begin
            valid_reg      <= valid_next;
            data_reg       <= data_next;
            channel_reg    <= channel_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign valid_o   = valid_reg;
    assign data_o    = data_reg;
    assign channel_o = channel_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: reset, fixed-mode sweep, round-robin order,
// backpressure and mid-operation reset, with a producer-stability monitor.
module tb_stream_mux_rr;

    logic             clk;
    logic             srst_i;
    logic [3:0][1:0]  data_i;
    logic [3:0]       valid_i;
    logic [3:0]       ready_o;
    logic             mode_i;
    logic [1:0]       direction_i;
    logic [1:0]       data_o;
    logic             valid_o;
    logic [1:0]       channel_o;
    logic             ready_i;

    int errors = 0;
    int checks = 0;

    logic             stab_en = 1'b0;
    logic             stab_armed = 1'b0;
    logic [3:0]       prev_valid;
    logic [3:0][1:0]  prev_data;
    logic [3:0]       prev_xfer;

    stream_mux_rr #(
        .DWIDTH   (2),
        .CHANNELS (4)
    ) dut (
        .clk_i       (clk),
        .srst_i      (srst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .mode_i      (mode_i),
        .direction_i (direction_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .channel_o   (channel_o),
        .ready_i     (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; a waiting (valid, not transferred) channel must keep valid and data.
    task automatic step();
        #1;
        if (stab_en && stab_armed) begin
            for (int k = 0; k < 4; k++) begin
                if (prev_valid[k] && !prev_xfer[k]) begin
                    check($sformatf("stable_ch%0d", k), {29'd0, valid_i[k], data_i[k]},
                          {29'd0, 1'b1, prev_data[k]});
                end
            end
        end
        stab_armed = stab_en;
        prev_valid = valid_i;
        prev_data  = data_i;
        prev_xfer  = valid_i & ready_o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] vec;
        int         dir;

        srst_i      = 1'b1;
        valid_i     = 4'b1111;
        data_i      = 8'b11_10_01_00;
        mode_i      = 1'b1;
        direction_i = 2'd0;
        ready_i     = 1'b0;

        // Reset held for three cycles with every producer requesting.
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_data", 32'(data_o), 32'd0);
            check("rst_chan", 32'(channel_o), 32'd0);
            check("rst_ready", 32'(ready_o), 32'd0);
        end

        // Fixed mode sweep over direction and all four data fields.
        srst_i  = 1'b0;
        mode_i  = 1'b0;
        ready_i = 1'b1;
        valid_i = 4'b1111;
        for (int v = 0; v < 1024; v++) begin
            vec         = 10'(v);
            direction_i = vec[9:8];
            data_i      = vec[7:0];
            dir         = int'(vec[9:8]);
            #1;
            check("fix_ready", 32'(ready_o), 32'(1) << dir);
            step();
            check("fix_data", 32'(data_o), (32'(v) >> (2 * dir)) & 32'd3);
            check("fix_chan", 32'(channel_o), 32'(dir));
            check("fix_valid", 32'(valid_o), 32'd1);
        end

        // Round robin with all channels requesting: 0,1,2,3,0,... no bubbles.
        mode_i  = 1'b1;
        data_i  = 8'b11_10_01_00;
        valid_i = 4'b1111;
        stab_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_ready", 32'(ready_o), 32'(1) << (i % 4));
            step();
            check("rr_chan", 32'(channel_o), 32'(i % 4));
            check("rr_data", 32'(data_o), 32'(i % 4));
            check("rr_valid", 32'(valid_o), 32'd1);
        end

        // Move last_grant to channel 1, then sparse requests 1010 must skip.
        stab_en = 1'b0;
        valid_i = 4'b0010;
        step();
        check("skip_prep_chan", 32'(channel_o), 32'd1);
        valid_i = 4'b1010;
        stab_en = 1'b1;
        #1;
        check("skip_ready0", 32'(ready_o), 32'b1000);
        step();
        check("skip_chan0", 32'(channel_o), 32'd3);
        check("skip_ready1", 32'(ready_o), 32'b0010);
        step();
        check("skip_chan1", 32'(channel_o), 32'd1);
        check("skip_ready2", 32'(ready_o), 32'b1000);
        step();
        check("skip_chan2", 32'(channel_o), 32'd3);
        check("skip_data2", 32'(data_o), 32'd3);

        // Fill buffer with 2'b10 from channel 2, then stall for five cycles.
        stab_en     = 1'b0;
        mode_i      = 1'b0;
        direction_i = 2'd2;
        valid_i     = 4'b1111;
        #1;
        check("bp_fill_ready", 32'(ready_o), 32'b0100);
        step();
        check("bp_fill_data", 32'(data_o), 32'd2);
        ready_i = 1'b0;
        mode_i  = 1'b1;
        stab_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", 32'(ready_o), 32'd0);
            step();
            check("bp_data", 32'(data_o), 32'd2);
            check("bp_chan", 32'(channel_o), 32'd2);
            check("bp_valid", 32'(valid_o), 32'd1);
        end
        // Releasing backpressure loads the next round-robin word on the same edge.
        ready_i = 1'b1;
        #1;
        check("bp_release_ready", 32'(ready_o), 32'b1000);
        step();
        check("bp_next_data", 32'(data_o), 32'd3);
        check("bp_next_chan", 32'(channel_o), 32'd3);
        check("bp_next_valid", 32'(valid_o), 32'd1);

        // Reset while stalled with a full buffer.
        stab_en = 1'b0;
        ready_i = 1'b0;
        step();
        check("mrst_pre_valid", 32'(valid_o), 32'd1);
        srst_i = 1'b1;
        #1;
        check("mrst_ready", 32'(ready_o), 32'd0);
        step();
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_data", 32'(data_o), 32'd0);
        check("mrst_chan", 32'(channel_o), 32'd0);
        srst_i  = 1'b0;
        ready_i = 1'b1;
        #1;
        check("mrst_rr_ready0", 32'(ready_o), 32'b0001);
        step();
        check("mrst_rr_chan0", 32'(channel_o), 32'd0);
        check("mrst_rr_valid0", 32'(valid_o), 32'd1);
        check("mrst_rr_ready1", 32'(ready_o), 32'b0010);
        step();
        check("mrst_rr_chan1", 32'(channel_o), 32'd1);
        check("mrst_rr_data1", 32'(data_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
